frac_interp_sequencer: RTL and testbench

- Control block for the two fractional interpolators (horizontal, vertical) in the scandoubler scaler path.
- Measures the active width and height of the source frame from its DE/VS timing.
- On a geometry change, reprograms the horizontal interpolator and then the vertical one, one after the other, waiting for each divider handshake.
- Gates the scaler output with a valid flag and drives the per-line and per-frame step_reset strobes.

---
 rtl/frac_interp_pkg.sv | 17 +
 rtl/frac_interp_measure.sv | 86 ++++++++
 rtl/frac_interp_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_frac_interp_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_interp_pkg.sv
// Shared types and defaults for the fractional interpolator sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package frac_interp_pkg;

    localparam int DEF_BITWIDTH = 10;
    localparam int DEF_MIN_SIZE = 16;

    typedef enum logic [2:0] {
        IDLE,
        H_REQ,
        H_WAIT,
        V_REQ,
        V_WAIT
    } seq_state_t;

endpackage

// File: rtl/frac_interp_measure.sv
// Measures source active width/height from DE/VS and emits the line/frame step strobes.
// Latency: frame_end, meas_w/meas_h and both strobes appear 1 clk after the sampled edge.
// Backpressure: none; the measurement free-runs on src_ce and cannot be stalled.
module frac_interp_measure
    import frac_interp_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                src_ce,
    input  logic                src_de,
    input  logic                src_hs,
    input  logic                src_vs,
    output logic                frame_end,
    output logic [BITWIDTH-1:0] meas_w,
    output logic [BITWIDTH-1:0] meas_h,
    output logic                h_step_reset,
    output logic                v_step_reset
);

    localparam logic [BITWIDTH-1:0] CNT_MAX = '1;

    logic                de_q, hs_q, vs_q;
    logic                de_rise, de_fall, hs_rise, vs_rise;
    logic [BITWIDTH-1:0] wcnt, wmax, hcnt;
    logic [BITWIDTH-1:0] wmax_nxt, hcnt_nxt;

    assign de_rise = src_ce &  src_de & ~de_q;
    assign de_fall = src_ce & ~src_de &  de_q;
    assign hs_rise = src_ce &  src_hs & ~hs_q;
    assign vs_rise = src_ce &  src_vs & ~vs_q;

    // Line-end max and line count including this cycle, so a frame end never misses a coincident edge
    always_comb begin
        wmax_nxt = wmax;
        hcnt_nxt = hcnt;
        if (de_fall && (wcnt > wmax)) begin
            wmax_nxt = wcnt;
        end
        if (de_rise && (hcnt != CNT_MAX)) begin
            hcnt_nxt = hcnt + 1'b1;
        end
    end

    // Edge history, saturating counters, frame-end capture and strobe generation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q         <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            wcnt         <= '0;
            wmax         <= '0;
            hcnt         <= '0;
            meas_w       <= '0;
            meas_h       <= '0;
            frame_end    <= 1'b0;
            h_step_reset <= 1'b0;
            v_step_reset <= 1'b0;
        end else begin
            frame_end    <= vs_rise;
            h_step_reset <= hs_rise;
            v_step_reset <= vs_rise;
            if (src_ce) begin
                de_q <= src_de;
                hs_q <= src_hs;
                vs_q <= src_vs;
            end
            if (de_fall) begin
                wcnt <= '0;
            end else if (src_ce && src_de && (wcnt != CNT_MAX)) begin
                wcnt <= wcnt + 1'b1;
            end
            if (vs_rise) begin
                meas_w <= wmax_nxt;
                meas_h <= hcnt_nxt;
                wmax   <= '0;
                hcnt   <= '0;
            end else begin
                wmax <= wmax_nxt;
                hcnt <= hcnt_nxt;
            end
        end
    end

endmodule

// File: rtl/frac_interp_sequencer.sv
// Programs the H then V fractional interpolators whenever the source geometry or target size changes.
// Latency: scale_valid rises >= 4 clk after the triggering frame end, plus both divider times.
// Backpressure: each newfraction waits for its ready; FRAC_INTERP_SEQ_STABLE_EN adds a two-frame size filter.
module frac_interp_sequencer
    import frac_interp_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int MIN_SIZE = DEF_MIN_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                src_ce,
    input  logic                src_de,
    input  logic                src_hs,
    input  logic                src_vs,
    input  logic [BITWIDTH-1:0] dst_w,
    input  logic [BITWIDTH-1:0] dst_h,
    output logic [BITWIDTH-1:0] h_num,
    output logic [BITWIDTH-1:0] h_den,
    output logic [BITWIDTH-1:0] v_num,
    output logic [BITWIDTH-1:0] v_den,
    output logic                h_newfraction,
    output logic                v_newfraction,
    input  logic                h_ready,
    input  logic                v_ready,
    output logic                h_step_reset,
    output logic                v_step_reset,
    output logic                scale_valid,
    output logic [BITWIDTH-1:0] src_w,
    output logic [BITWIDTH-1:0] src_h
);

    localparam logic [BITWIDTH-1:0] MIN_VAL = BITWIDTH'(MIN_SIZE);

    seq_state_t          state;
    logic                frame_end;
    logic [BITWIDTH-1:0] meas_w, meas_h;
    logic                geo_evt, size_ok, geo_diff;
    logic [BITWIDTH-1:0] dst_w_q, dst_h_q;
    logic                dst_chg;
    logic                pend;
    logic [BITWIDTH-1:0] pend_w, pend_h;
    logic                ready_hold;
    logic                start, drop_valid, rec_meas, rec_dst;
    logic [BITWIDTH-1:0] start_w, start_h;

    frac_interp_measure #(.BITWIDTH(BITWIDTH)) u_measure (
        .clk          (clk),
        .reset        (reset),
        .src_ce       (src_ce),
        .src_de       (src_de),
        .src_hs       (src_hs),
        .src_vs       (src_vs),
        .frame_end    (frame_end),
        .meas_w       (meas_w),
        .meas_h       (meas_h),
        .h_step_reset (h_step_reset),
        .v_step_reset (v_step_reset)
    );

    assign h_num    = dst_w;
    assign v_num    = dst_h;
    assign size_ok  = (meas_w >= MIN_VAL) && (meas_h >= MIN_VAL);
    assign geo_diff = (meas_w != src_w) || (meas_h != src_h);
    assign dst_chg  = (dst_w != dst_w_q) || (dst_h != dst_h_q);

    // Previous target size, so a target change is seen as a one-cycle compare hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_w_q <= '0;
            dst_h_q <= '0;
        end else begin
            dst_w_q <= dst_w;
            dst_h_q <= dst_h;
        end
    end

`ifdef FRAC_INTERP_SEQ_STABLE_EN
    logic                cand_vld;
    logic [BITWIDTH-1:0] cand_w, cand_h;

    // Last frame's size: a new size only counts once it repeats on the next frame end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_vld <= 1'b0;
            cand_w   <= '0;
            cand_h   <= '0;
        end else if (frame_end) begin
            cand_vld <= 1'b1;
            cand_w   <= meas_w;
            cand_h   <= meas_h;
        end
    end

    assign geo_evt = frame_end &&
                     (!geo_diff || (cand_vld && (cand_w == meas_w) && (cand_h == meas_h)));
`else
    assign geo_evt = frame_end;
`endif

    // Decide whether IDLE restarts (and with which size) and what a busy state must remember
    always_comb begin
        start      = 1'b0;
        drop_valid = 1'b0;
        start_w    = src_w;
        start_h    = src_h;
        if (geo_evt && !size_ok) begin
            drop_valid = 1'b1;
        end else if (geo_evt && (geo_diff || !scale_valid || pend || dst_chg)) begin
            start   = 1'b1;
            start_w = meas_w;
            start_h = meas_h;
        end else if (pend) begin
            start   = 1'b1;
            start_w = pend_w;
            start_h = pend_h;
        end else if (dst_chg && scale_valid) begin
            start = 1'b1;
        end
        // Undersized frames while busy are ignored; a newer size always replaces an older pending one
        rec_meas = geo_evt && size_ok && (geo_diff || pend);
        rec_dst  = !rec_meas && dst_chg && !pend;
    end

    // Sequencer FSM: H request, H wait, V request, V wait; pending changes replay from IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            scale_valid   <= 1'b0;
            src_w         <= '0;
            src_h         <= '0;
            h_den         <= '0;
            v_den         <= '0;
            h_newfraction <= 1'b0;
            v_newfraction <= 1'b0;
            pend          <= 1'b0;
            pend_w        <= '0;
            pend_h        <= '0;
            ready_hold    <= 1'b0;
        end else begin
            h_newfraction <= 1'b0;
            v_newfraction <= 1'b0;
            if (state != IDLE) begin
                if (rec_meas) begin
                    pend   <= 1'b1;
                    pend_w <= meas_w;
                    pend_h <= meas_h;
                end else if (rec_dst) begin
                    pend   <= 1'b1;
                    pend_w <= src_w;
                    pend_h <= src_h;
                end
            end
            case (state)
                IDLE: begin
                    if (drop_valid) begin
                        scale_valid <= 1'b0;
                    end else if (start) begin
                        src_w         <= start_w;
                        src_h         <= start_h;
                        h_den         <= start_w;
                        scale_valid   <= 1'b0;
                        pend          <= 1'b0;
                        h_newfraction <= 1'b1;
                        state         <= H_REQ;
                    end
                end
                H_REQ: begin
                    ready_hold <= 1'b1;
                    state      <= H_WAIT;
                end
                H_WAIT: begin
                    // Interpolator drops ready only after seeing the pulse, so skip one cycle
                    if (ready_hold) begin
                        ready_hold <= 1'b0;
                    end else if (h_ready) begin
                        v_den         <= src_h;
                        v_newfraction <= 1'b1;
                        state         <= V_REQ;
                    end
                end
                V_REQ: begin
                    ready_hold <= 1'b1;
                    state      <= V_WAIT;
                end
                V_WAIT: begin
                    if (ready_hold) begin
                        ready_hold <= 1'b0;
                    end else if (v_ready) begin
                        scale_valid <= !(pend || rec_meas || rec_dst);
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frac_interp_sequencer.sv
// Randomized bench for frac_interp_sequencer with a frame-level reference model and pulse scoreboard.
// Latency: expected geometries are queued at frame end and consumed when newfraction pulses appear.
// Backpressure: bench models both interpolators, holding ready low for a programmable divider time.
module tb_frac_interp_sequencer;
    import frac_interp_pkg::*;

    localparam int BW   = DEF_BITWIDTH;
    localparam int MAXV = (1 << BW) - 1;
    localparam int MINS = DEF_MIN_SIZE;

    logic          clk = 1'b0;
    logic          reset;
    logic          src_ce, src_de, src_hs, src_vs;
    logic [BW-1:0] dst_w, dst_h, h_num, h_den, v_num, v_den, src_w, src_h;
    logic          h_newfraction, v_newfraction, h_ready, v_ready;
    logic          h_step_reset, v_step_reset, scale_valid;

    always #5 clk = ~clk;

    frac_interp_sequencer #(.BITWIDTH(BW), .MIN_SIZE(MINS)) dut (
        .clk           (clk),
        .reset         (reset),
        .src_ce        (src_ce),
        .src_de        (src_de),
        .src_hs        (src_hs),
        .src_vs        (src_vs),
        .dst_w         (dst_w),
        .dst_h         (dst_h),
        .h_num         (h_num),
        .h_den         (h_den),
        .v_num         (v_num),
        .v_den         (v_den),
        .h_newfraction (h_newfraction),
        .v_newfraction (v_newfraction),
        .h_ready       (h_ready),
        .v_ready       (v_ready),
        .h_step_reset  (h_step_reset),
        .v_step_reset  (v_step_reset),
        .scale_valid   (scale_valid),
        .src_w         (src_w),
        .src_h         (src_h)
    );

    typedef struct { int w; int h; } geo_t;
    geo_t exp_q[$];

    int n_cmp = 0, n_bad = 0;
    int ce_div = 1, h_delay = 20, v_delay = 20;
    int hs_sent = 0, frames_sent = 0, hs_seen = 0, vs_seen = 0, both_seen = 0;

    // reference model state (frame-level view of the sequencer)
    int acc_w = 0, acc_h = 0, pend_w = 0, pend_h = 0, prev_w = 0, prev_h = 0;
    bit valid_exp = 0, inflight = 0, has_pend = 0, prev_vld = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input int w, input int h);
        exp_q.push_back('{w, h});
        acc_w = w; acc_h = h; valid_exp = 0; inflight = 1;
    endtask

    // frame end with a source of w x h: apply the sequencing rules
    task automatic model_frame(input int w, input int h);
        int mw, mh;
        bit big, pass;
        mw = (w > MAXV) ? MAXV : w;
        mh = (h > MAXV) ? MAXV : h;
        pass = 1;
`ifdef FRAC_INTERP_SEQ_STABLE_EN
        pass = (mw == acc_w && mh == acc_h) || (prev_vld && mw == prev_w && mh == prev_h);
        prev_vld = 1; prev_w = mw; prev_h = mh;
`endif
        if (pass) begin
            big = (mw >= MINS) && (mh >= MINS);
            if (inflight) begin
                if (big && (mw != acc_w || mh != acc_h || has_pend)) begin
                    has_pend = 1; pend_w = mw; pend_h = mh;
                end
            end else if (!big) begin
                valid_exp = 0;
            end else if (mw != acc_w || mh != acc_h || !valid_exp) begin
                model_push(mw, mh);
            end
        end
    endtask

    task automatic model_dst();
        if (inflight) begin
            if (!has_pend) begin
                has_pend = 1; pend_w = acc_w; pend_h = acc_h;
            end
        end else if (valid_exp) begin
            model_push(acc_w, acc_h);
        end
    endtask

    task automatic model_done();
        if (has_pend) begin
            has_pend = 0;
            model_push(pend_w, pend_h);
        end else begin
            inflight = 0;
            valid_exp = 1;
        end
    endtask

    // Interpolator models plus monitor/scoreboard, sampled on the falling edge
    initial begin : responder
        geo_t cur;
        int   h_cnt, v_cnt;
        bit   h_out, v_out;
        cur = '{0, 0}; h_cnt = 0; v_cnt = 0; h_out = 0; v_out = 0;
        h_ready = 1'b1; v_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (h_step_reset) hs_seen++;
                if (v_step_reset) vs_seen++;
                if (h_step_reset && v_step_reset) both_seen++;
                if (h_newfraction) begin
                    check("h_reissue", int'(h_out), 0);
                    check("h_num", int'(h_num), int'(dst_w));
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL h_unexpected: got pulse with h_den=%0d, expected no pulse", h_den);
                        cur = '{-1, -1};
                    end else begin
                        cur = exp_q.pop_front();
                        check("h_den", int'(h_den), cur.w);
                    end
                    h_out = 1; h_cnt = h_delay; h_ready = 1'b0;
                end else if (h_out) begin
                    h_cnt--;
                    if (h_cnt <= 0) begin h_out = 0; h_ready = 1'b1; end
                end
                if (v_newfraction) begin
                    check("v_order", int'(h_out), 0);
                    check("v_reissue", int'(v_out), 0);
                    check("v_num", int'(v_num), int'(dst_h));
                    check("v_den", int'(v_den), cur.h);
                    v_out = 1; v_cnt = v_delay; v_ready = 1'b0;
                end else if (v_out) begin
                    v_cnt--;
                    if (v_cnt <= 0) begin v_out = 0; v_ready = 1'b1; model_done(); end
                end
            end
        end
    end

    task automatic tick(input bit de, input bit hs, input bit vs);
        for (int k = 0; k < ce_div; k++) begin
            src_ce = (k == 0);
            src_de = de; src_hs = hs; src_vs = vs;
            @(posedge clk); #1;
        end
    endtask

    // one source frame: h lines, one of them exactly w pixels wide, then a vsync with hsync
    task automatic send_frame(input int w, input int h);
        int longest, len, cap;
        longest = $urandom_range(h - 1, 0);
        cap = (w < 8) ? w : 8;
        for (int l = 0; l < h; l++) begin
            len = (l == longest) ? w : int'($urandom_range(cap, 1));
            tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
            repeat (len) tick(1, 0, 0);
            tick(0, 0, 0);
            hs_sent++;
        end
        tick(0, 1, 1);
        model_frame(w, h);
        frames_sent++; hs_sent++;
        tick(0, 0, 1); tick(0, 0, 0);
    endtask

    task automatic settle();
        int t;
        t = 0;
        repeat (8) @(posedge clk);
        while (inflight && t < 4000) begin @(posedge clk); t++; end
        check("settle_timeout", int'(inflight), 0);
        repeat (4) @(posedge clk); #1;
        check("scale_valid", int'(scale_valid), int'(valid_exp));
        check("src_w", int'(src_w), acc_w);
        check("src_h", int'(src_h), acc_h);
    endtask

    initial begin : stim
        int rw, rh;
        rw = 64; rh = 32;
        reset = 1'b1; src_ce = 1'b0; src_de = 1'b0; src_hs = 1'b0; src_vs = 1'b0;
        dst_w = 10'd720; dst_h = 10'd480;
        repeat (3) @(posedge clk); #1;
        check("rst_h_newfraction", int'(h_newfraction), 0);
        check("rst_v_newfraction", int'(v_newfraction), 0);
        check("rst_scale_valid", int'(scale_valid), 0);
        check("rst_src_w", int'(src_w), 0);
        check("rst_h_den", int'(h_den), 0);
        check("rst_v_den", int'(v_den), 0);
        check("rst_strobes", int'(h_step_reset) + int'(v_step_reset), 0);
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;

        // steady 640x240: one programming, then quiet frames
        repeat (3) begin send_frame(640, 240); settle(); end

        // size switch: valid drops at the first new frame end
        send_frame(320, 200);
        repeat (4) @(posedge clk); #1;
        check("valid_drop", int'(scale_valid), int'(valid_exp));
        settle();
        send_frame(320, 200); settle();

        // size changes while the horizontal divider is slow
        h_delay = 500;
        send_frame(400, 100);
        send_frame(24, 18);
        send_frame(40, 20);
        settle();
        h_delay = 20;

        // undersized source
        send_frame(8, 20); settle();
        send_frame(8, 20); settle();

        // half-rate source wider than the counter range
        ce_div = 2;
        send_frame(1024, 20); settle();
        ce_div = 1;

        // target size change with valid geometry
        dst_w = 10'd800;
        model_dst();
        settle();

        // one-frame glitch, then a real switch
        send_frame(640, 240); settle();
        send_frame(600, 240); settle();
        send_frame(640, 240); settle();
        send_frame(600, 240); settle();
        send_frame(600, 240); settle();

        // random geometries, including repeats and undersized ones
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || $urandom_range(2, 0) != 0) begin
                rw = $urandom_range(150, 4);
                rh = $urandom_range(40, 4);
            end
            send_frame(rw, rh);
            settle();
        end

        repeat (10) @(posedge clk); #1;
        check("queue_left", exp_q.size(), 0);
        check("h_strobes", hs_seen, hs_sent);
        check("v_strobes", vs_seen, frames_sent);
        check("hv_same_cycle", both_seen, frames_sent);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
